fp_mul_operand_ctrl: RTL and testbench
======================================

# fp_mul_operand_ctrl

Sequencing controller that sits in front of the floating-point multiplier datapath and shares a single operand analyzer (sign, 8-bit exponent, DATA_W-9 fraction format) between the two multiplicand operands. It accepts an operand pair over a valid/ready handshake and classifies A, then B, through the one analyzer instance on consecutive cycles. It then either dispatches unpacked operands to the multiplier or short-circuits the special cases (NaN, Inf, zero) to a final result with an invalid flag.

## Interface
- DATA_W, 32, operand width; bit DATA_W-1 sign, [DATA_W-2:DATA_W-9] exponent, [DATA_W-10:0] fraction

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  controller can accept a pair
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- out_valid  out  1  result/dispatch valid
- out_ready  in  1  consumer accepts
- out_special  out  1  1: out_data is final result; 0: dispatch fields are valid for the multiplier
- out_data  out  DATA_W  special-case result; 0 when out_special=0
- out_invalid  out  1  IEEE invalid-operation flag
- out_sign  out  1  sign_a XOR sign_b
- out_exp_a, out_exp_b  out  8  raw biased exponents
- out_mant_a, out_mant_b  out  DATA_W-8  {hidden bit, fraction}; hidden bit = 0 for zero/denormal, else 1
- busy  out  1  state != IDLE

## Operation
- One analyzer instance, combinational, input muxed by FSM: A in ANA_A, B in ANA_B.
- Class per operand: ZERO (exp=0, frac=0), DENORM (exp=0, frac!=0), INF (exp=all-ones, frac=0), NAN (exp=all-ones, frac!=0), qNaN if fraction MSB=1, else sNaN.
- FSM: IDLE -> (in_valid & in_ready) -> ANA_A -> ANA_B -> OUT -> (out_ready) -> IDLE.
- IDLE: in_ready=1; captures in_a, in_b into operand registers on handshake.
- ANA_A: registers class and unpacked fields of A. ANA_B: same for B.
- OUT: decision registered on entry; out_valid=1; all out_* held stable until out_ready.
- Decision priority, first match wins:
  - any NaN -> special, canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0); invalid=1 if either operand is sNaN.
  - INF * ZERO (either order) -> special, canonical qNaN, invalid=1.
  - either INF -> special, {out_sign, all-ones, 0}, invalid=0.
  - either ZERO -> special, {out_sign, 0, 0}, invalid=0.
  - else -> out_special=0, dispatch fields valid, invalid=0. Denormals go to dispatch.
- Dispatch fields (sign, exp, mant) are driven in every OUT cycle regardless of out_special.

## Timing
- Reset: state IDLE; out_valid, out_special, out_data, out_invalid, out_sign, out_exp_*, out_mant_*, busy all 0.
- in_ready = (state==IDLE) & ~rst. It is 0 in any cycle with rst high.
- Latency: handshake at edge T -> ANA_A cycle T+1 -> ANA_B cycle T+2 -> out_valid high from cycle T+3.
- Max throughput 1 pair / 4 cycles. in_ready returns the cycle after the out handshake.
- out_ready low: stay in OUT, outputs frozen, in_ready=0, no new pair accepted.
- out_ready high on first OUT cycle: out_valid lasts exactly 1 cycle.
- in_valid while busy: ignored, not captured.
- rst in any state: next cycle IDLE, transaction dropped, out_valid 0, no partial result ever presented.
- out_* deassert to 0 on the edge leaving OUT.

## Configuration
- FP_NAN_PROPAGATE_EN defined: NaN result propagates the input payload instead of canonical qNaN. Source is A if A is NaN, else B. Sign and payload are kept, fraction MSB is forced to 1 (quieted). Inf*0 still yields canonical qNaN.
- Undefined: all NaN results are the canonical qNaN.

## Test plan
- Normal, DATA_W=32: A=0x40400000, B=0xC0000000 -> at T+3: out_special=0, sign=1, exp_a=exp_b=0x80, mant_a=0xC00000, mant_b=0x800000, invalid=0.
- Inf*0: A=0x7F800000, B=0x00000000 -> out_special=1, out_data=0x7FC00000, invalid=1. Swapped order gives the same result.
- Signed Inf: A=0xFF800000, B=0x40000000 -> out_data=0xFF800000, invalid=0. A=0x80000000, B=0x40400000 -> out_data=0x80000000.
- sNaN: A=0x3F800000, B=0xFF800001 -> invalid=1. out_data=0x7FC00000 without macro, 0xFFC00001 with FP_NAN_PROPAGATE_EN.
- Backpressure: out_ready low 5 cycles in OUT -> out_* constant, in_ready=0, new in_valid ignored. out_ready high -> out_valid 1 cycle, in_ready=1 next cycle.
- Reset mid-op: rst high one cycle during ANA_B -> out_valid stays 0, in_ready=1 the cycle after rst drops, next pair processed correctly.

Source files
------------

// File: rtl/fp_mul_operand_ctrl.sv
// Operand sequencing controller for the FP multiplier: one shared analyzer classifies A then B,
// then either dispatches unpacked operands or resolves NaN/Inf/zero cases. Optional macro: FP_NAN_PROPAGATE_EN.
module fp_mul_operand_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_special,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_invalid,
    output logic                out_sign,
    output logic [7:0]          out_exp_a,
    output logic [7:0]          out_exp_b,
    output logic [DATA_W-9:0]   out_mant_a,
    output logic [DATA_W-9:0]   out_mant_b,
    output logic                busy
);
    localparam int FW = DATA_W - 9;
    localparam int MW = DATA_W - 8;

    typedef enum logic [1:0] {IDLE, ANA_A, ANA_B, OUT} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;

    logic          a_sign_q, a_sign_d;
    logic          a_zero_q, a_zero_d;
    logic          a_inf_q, a_inf_d;
    logic          a_nan_q, a_nan_d;
    logic          a_snan_q, a_snan_d;
    logic [7:0]    a_exp_q, a_exp_d;
    logic [MW-1:0] a_mant_q, a_mant_d;

    logic              out_valid_q, out_valid_d;
    logic              out_special_q, out_special_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_invalid_q, out_invalid_d;
    logic              out_sign_q, out_sign_d;
    logic [7:0]        out_exp_a_q, out_exp_a_d;
    logic [7:0]        out_exp_b_q, out_exp_b_d;
    logic [MW-1:0]     out_mant_a_q, out_mant_a_d;
    logic [MW-1:0]     out_mant_b_q, out_mant_b_d;

    // Shared analyzer: the FSM state selects which captured operand it sees.
    logic [DATA_W-1:0] ana_in;
    logic              ana_sign, ana_zero, ana_inf, ana_nan, ana_snan;
    logic [7:0]        ana_exp;
    logic [FW-1:0]     ana_frac;
    logic [MW-1:0]     ana_mant;

    always_comb begin
        ana_in   = (state_q == ANA_B) ? opb_q : opa_q;
        ana_sign = ana_in[DATA_W-1];
        ana_exp  = ana_in[DATA_W-2:DATA_W-9];
        ana_frac = ana_in[FW-1:0];
        ana_zero = (ana_exp == 8'h00) && (ana_frac == '0);
        ana_inf  = (ana_exp == 8'hFF) && (ana_frac == '0);
        ana_nan  = (ana_exp == 8'hFF) && (ana_frac != '0);
        ana_snan = ana_nan && !ana_frac[FW-1];
        ana_mant = {(ana_exp != 8'h00), ana_frac};
    end

    logic              any_nan, any_snan, inf_times_zero, any_inf, any_zero, res_sign;
    logic [DATA_W-1:0] canon_qnan, nan_result;

    always_comb begin
        canon_qnan     = {1'b0, 8'hFF, 1'b1, {(FW-1){1'b0}}};
        any_nan        = a_nan_q | ana_nan;
        any_snan       = a_snan_q | ana_snan;
        inf_times_zero = (a_inf_q & ana_zero) | (a_zero_q & ana_inf);
        any_inf        = a_inf_q | ana_inf;
        any_zero       = a_zero_q | ana_zero;
        res_sign       = a_sign_q ^ ana_sign;
`ifdef FP_NAN_PROPAGATE_EN
        nan_result = a_nan_q ? {opa_q[DATA_W-1], 8'hFF, 1'b1, opa_q[FW-2:0]}
                             : {opb_q[DATA_W-1], 8'hFF, 1'b1, opb_q[FW-2:0]};
`else
        nan_result = canon_qnan;
`endif
    end

    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        a_sign_d      = a_sign_q;
        a_zero_d      = a_zero_q;
        a_inf_d       = a_inf_q;
        a_nan_d       = a_nan_q;
        a_snan_d      = a_snan_q;
        a_exp_d       = a_exp_q;
        a_mant_d      = a_mant_q;
        out_valid_d   = out_valid_q;
        out_special_d = out_special_q;
        out_data_d    = out_data_q;
        out_invalid_d = out_invalid_q;
        out_sign_d    = out_sign_q;
        out_exp_a_d   = out_exp_a_q;
        out_exp_b_d   = out_exp_b_q;
        out_mant_a_d  = out_mant_a_q;
        out_mant_b_d  = out_mant_b_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = in_a;
                    opb_d   = in_b;
                    state_d = ANA_A;
                end
            end
            ANA_A: begin
                a_sign_d = ana_sign;
                a_zero_d = ana_zero;
                a_inf_d  = ana_inf;
                a_nan_d  = ana_nan;
                a_snan_d = ana_snan;
                a_exp_d  = ana_exp;
                a_mant_d = ana_mant;
                state_d  = ANA_B;
            end
            ANA_B: begin
                // B is decided straight off the analyzer so the result registers on OUT entry.
                out_valid_d   = 1'b1;
                out_sign_d    = res_sign;
                out_exp_a_d   = a_exp_q;
                out_exp_b_d   = ana_exp;
                out_mant_a_d  = a_mant_q;
                out_mant_b_d  = ana_mant;
                out_special_d = 1'b1;
                out_invalid_d = 1'b0;
                if (any_nan) begin
                    out_data_d    = nan_result;
                    out_invalid_d = any_snan;
                end else if (inf_times_zero) begin
                    out_data_d    = canon_qnan;
                    out_invalid_d = 1'b1;
                end else if (any_inf) begin
                    out_data_d = {res_sign, 8'hFF, {FW{1'b0}}};
                end else if (any_zero) begin
                    out_data_d = {res_sign, {(DATA_W-1){1'b0}}};
                end else begin
                    out_special_d = 1'b0;
                    out_data_d    = '0;
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    out_special_d = 1'b0;
                    out_data_d    = '0;
                    out_invalid_d = 1'b0;
                    out_sign_d    = 1'b0;
                    out_exp_a_d   = '0;
                    out_exp_b_d   = '0;
                    out_mant_a_d  = '0;
                    out_mant_b_d  = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            opa_q         <= '0;
            opb_q         <= '0;
            a_sign_q      <= 1'b0;
            a_zero_q      <= 1'b0;
            a_inf_q       <= 1'b0;
            a_nan_q       <= 1'b0;
            a_snan_q      <= 1'b0;
            a_exp_q       <= '0;
            a_mant_q      <= '0;
            out_valid_q   <= 1'b0;
            out_special_q <= 1'b0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_sign_q    <= 1'b0;
            out_exp_a_q   <= '0;
            out_exp_b_q   <= '0;
            out_mant_a_q  <= '0;
            out_mant_b_q  <= '0;
        end else begin
            state_q       <= state_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            a_sign_q      <= a_sign_d;
            a_zero_q      <= a_zero_d;
            a_inf_q       <= a_inf_d;
            a_nan_q       <= a_nan_d;
            a_snan_q      <= a_snan_d;
            a_exp_q       <= a_exp_d;
            a_mant_q      <= a_mant_d;
            out_valid_q   <= out_valid_d;
            out_special_q <= out_special_d;
            out_data_q    <= out_data_d;
            out_invalid_q <= out_invalid_d;
            out_sign_q    <= out_sign_d;
            out_exp_a_q   <= out_exp_a_d;
            out_exp_b_q   <= out_exp_b_d;
            out_mant_a_q  <= out_mant_a_d;
            out_mant_b_q  <= out_mant_b_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign out_special = out_special_q;
    assign out_data    = out_data_q;
    assign out_invalid = out_invalid_q;
    assign out_sign    = out_sign_q;
    assign out_exp_a   = out_exp_a_q;
    assign out_exp_b   = out_exp_b_q;
    assign out_mant_a  = out_mant_a_q;
    assign out_mant_b  = out_mant_b_q;

endmodule

// File: tb/tb_fp_mul_operand_ctrl.sv
// Randomized self-checking bench for fp_mul_operand_ctrl with an IEEE-rule reference model.
// Handshake: a pair transfers on a rising edge with in_valid & in_ready; a result on out_valid & out_ready.
module tb_fp_mul_operand_ctrl;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic              out_special;
    logic [DATA_W-1:0] out_data;
    logic              out_invalid;
    logic              out_sign;
    logic [7:0]        out_exp_a;
    logic [7:0]        out_exp_b;
    logic [23:0]       out_mant_a;
    logic [23:0]       out_mant_b;
    logic              busy;

    fp_mul_operand_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_special(out_special),
        .out_data(out_data), .out_invalid(out_invalid), .out_sign(out_sign),
        .out_exp_a(out_exp_a), .out_exp_b(out_exp_b),
        .out_mant_a(out_mant_a), .out_mant_b(out_mant_b), .busy(busy)
    );

    typedef struct packed {
        logic        special;
        logic [31:0] data;
        logic        invalid;
        logic        sign;
        logic [7:0]  exp_a;
        logic [7:0]  exp_b;
        logic [23:0] mant_a;
        logic [23:0] mant_b;
    } res_t;

    res_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model straight from the IEEE classification and decision priority.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int unsigned ea, eb, fa, fb;
        bit sa, sb, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
        logic [31:0] src;
        ea = (a >> 23) & 32'hFF;  eb = (b >> 23) & 32'hFF;
        fa = a % (1 << 23);       fb = b % (1 << 23);
        sa = a[31];               sb = b[31];
        nan_a  = (ea == 255) && (fa != 0);  nan_b  = (eb == 255) && (fb != 0);
        snan_a = nan_a && (fa < (1 << 22)); snan_b = nan_b && (fb < (1 << 22));
        inf_a  = (ea == 255) && (fa == 0);  inf_b  = (eb == 255) && (fb == 0);
        zero_a = (ea == 0) && (fa == 0);    zero_b = (eb == 0) && (fb == 0);
        r.sign   = sa ^ sb;
        r.exp_a  = ea[7:0];
        r.exp_b  = eb[7:0];
        r.mant_a = (ea != 0) ? 24'(fa + (1 << 23)) : 24'(fa);
        r.mant_b = (eb != 0) ? 24'(fb + (1 << 23)) : 24'(fb);
        r.special = 1'b1;
        r.invalid = 1'b0;
        if (nan_a || nan_b) begin
`ifdef FP_NAN_PROPAGATE_EN
            src    = nan_a ? a : b;
            r.data = src | 32'h7FC00000;
`else
            src    = 32'h7FC00000;
            r.data = src;
`endif
            r.invalid = snan_a || snan_b;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            r.data    = 32'h7FC00000;
            r.invalid = 1'b1;
        end else if (inf_a || inf_b) begin
            r.data = r.sign ? 32'hFF800000 : 32'h7F800000;
        end else if (zero_a || zero_b) begin
            r.data = r.sign ? 32'h80000000 : 32'h00000000;
        end else begin
            r.special = 1'b0;
            r.data    = 32'h0;
        end
        return r;
    endfunction

    function automatic res_t observe();
        res_t r;
        r.special = out_special; r.data = out_data; r.invalid = out_invalid; r.sign = out_sign;
        r.exp_a = out_exp_a; r.exp_b = out_exp_b; r.mant_a = out_mant_a; r.mant_b = out_mant_b;
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        logic [31:0] s;
        s = {$urandom_range(0, 1), 31'h0};
        case ($urandom_range(0, 6))
            0: v = s;
            1: v = s | ($urandom() % (1 << 23)) | 32'h1;
            2: v = s | 32'h7F800000;
            3: v = s | 32'h7FC00000 | ($urandom() % (1 << 22));
            4: v = s | 32'h7F800000 | ($urandom() % (1 << 22)) | 32'h1;
            5: v = s | ({$urandom_range(1, 254), 23'h0}) | ($urandom() % (1 << 23));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Sends one pair, checks latency and result, holds out_ready low for `hold` cycles.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int hold, input bit junk);
        res_t e;
        int   g;
        int   lat;
        exp_q.push_back(model(a, b));
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = junk; in_a = $urandom(); in_b = $urandom();
        lat = 1;
        while (!out_valid && lat < 10) begin
            check("busy_in_ready", {busy, in_ready}, 2'b10);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        e = exp_q.pop_front();
        check("special", out_special, e.special);
        check("data", out_data, e.data);
        check("invalid", out_invalid, e.invalid);
        check("sign", out_sign, e.sign);
        check("exp_a", out_exp_a, e.exp_a);
        check("exp_b", out_exp_b, e.exp_b);
        check("mant_a", out_mant_a, e.mant_a);
        check("mant_b", out_mant_b, e.mant_b);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid_ready", {out_valid, in_ready}, 2'b10);
            check("hold_stable", observe(), e);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", out_valid, 1'b0);
        check("release_zero", observe(), '0);
        check("release_in_ready", {in_ready, busy}, 2'b10);
    endtask

    task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_recover_ready", {in_ready, busy, out_valid}, 3'b100);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_no_result", out_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_state", {out_valid, busy}, 2'b00);
        check("reset_outputs", observe(), '0);
        rst = 1'b0;
        #1;
        check("reset_release_ready", in_ready, 1'b1);

        run_pair(32'h40400000, 32'hC0000000, 0, 1'b0);
        run_pair(32'h7F800000, 32'h00000000, 0, 1'b0);
        run_pair(32'h00000000, 32'h7F800000, 1, 1'b0);
        run_pair(32'hFF800000, 32'h40000000, 0, 1'b0);
        run_pair(32'h80000000, 32'h40400000, 0, 1'b0);
        run_pair(32'h3F800000, 32'hFF800001, 0, 1'b0);
        run_pair(32'h7FA00005, 32'h7FC00000, 0, 1'b0);
        run_pair(32'h00000001, 32'h3F800000, 0, 1'b0);
        run_pair(32'h40400000, 32'h3F000000, 5, 1'b1);

        reset_mid_op(32'h7F800000, 32'h00000000);
        run_pair(32'h40400000, 32'hC0000000, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            run_pair(rand_operand(), rand_operand(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
